// File: rtl/proc_state_seq_pkg.sv
// Shared definitions for the instruction-cycle sequencer: stage encodings and
// the default counter width.
package proc_state_seq_pkg;

   localparam int unsigned PROC_CNT_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      PROC_ST_IDLE      = 3'b000,
      PROC_ST_FETCH     = 3'b001,
      PROC_ST_DECODE    = 3'b010,
      PROC_ST_EXECUTE   = 3'b011,
      PROC_ST_MEMORY    = 3'b100,
      PROC_ST_WRITEBACK = 3'b101,
      PROC_ST_HALTED    = 3'b110
   } proc_state_e;

endpackage

// File: rtl/proc_wrap_counter.sv
// Synchronous-reset up-counter that wraps silently at 2^WIDTH.
module proc_wrap_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             INC,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (INC) cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign Q = cnt_q;

endmodule

// File: rtl/proc_state_seq.sv
// Five-stage fetch/decode/execute/memory/writeback sequencer with start, stall,
// halt and a retired-instruction count. PROC_CYCLE_CNT_EN adds a running-cycle counter.
module proc_state_seq
   import proc_state_seq_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = PROC_CNT_WIDTH_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 STALL,
   input  logic                 HALT,
   output logic [2:0]           STATE,
   output logic                 RUNNING,
   output logic                 STEP_DONE,
   output logic [CNT_WIDTH-1:0] INSTR_CNT
`ifdef PROC_CYCLE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] CYCLE_CNT
`endif
);

   proc_state_e state_q, state_d;
   logic        halt_pend_q, halt_pend_d;
   logic        step_done_q;
   logic        wb_exit;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= PROC_ST_IDLE;
         halt_pend_q <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
         step_done_q <= wb_exit;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      wb_exit     = 1'b0;
      case (state_q)
         PROC_ST_IDLE:    if (START) state_d = PROC_ST_FETCH;
         PROC_ST_FETCH:   if (!STALL) state_d = PROC_ST_DECODE;
         PROC_ST_DECODE: begin
            if (!STALL) begin
               state_d = PROC_ST_EXECUTE;
               if (HALT) halt_pend_d = 1'b1;
            end
         end
         PROC_ST_EXECUTE: if (!STALL) state_d = PROC_ST_MEMORY;
         PROC_ST_MEMORY:  if (!STALL) state_d = PROC_ST_WRITEBACK;
         PROC_ST_WRITEBACK: begin
            // A stalled writeback holds both the retire count and any pending halt.
            if (!STALL) begin
               wb_exit     = 1'b1;
               halt_pend_d = 1'b0;
               state_d     = halt_pend_q ? PROC_ST_HALTED : PROC_ST_FETCH;
            end
         end
         PROC_ST_HALTED:  state_d = PROC_ST_HALTED;
         default:         state_d = PROC_ST_IDLE;
      endcase
   end

   assign STATE     = state_q;
   assign RUNNING   = (state_q != PROC_ST_IDLE) && (state_q != PROC_ST_HALTED);
   assign STEP_DONE = step_done_q;

   proc_wrap_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
      .CLK (CLK),
      .RST (RST),
      .INC (wb_exit),
      .Q   (INSTR_CNT)
   );

`ifdef PROC_CYCLE_CNT_EN
   proc_wrap_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .CLK (CLK),
      .RST (RST),
      .INC (RUNNING),
      .Q   (CYCLE_CNT)
   );
`endif

endmodule

// File: tb/tb_proc_state_seq.sv
// Scoreboard bench for proc_state_seq: a stage-index reference model predicts every
// cycle's outputs; a monitor pops and compares. Honours PROC_CYCLE_CNT_EN.
module tb_proc_state_seq;

   localparam int W = 3;
   localparam int unsigned MASK = (1 << W) - 1;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic         STALL = 1'b0;
   logic         HALT = 1'b0;
   logic [2:0]   STATE;
   logic         RUNNING;
   logic         STEP_DONE;
   logic [W-1:0] INSTR_CNT;
`ifdef PROC_CYCLE_CNT_EN
   logic [W-1:0] CYCLE_CNT;
`endif

   proc_state_seq #(.CNT_WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .STALL     (STALL),
      .HALT      (HALT),
      .STATE     (STATE),
      .RUNNING   (RUNNING),
      .STEP_DONE (STEP_DONE),
      .INSTR_CNT (INSTR_CNT)
`ifdef PROC_CYCLE_CNT_EN
      ,
      .CYCLE_CNT (CYCLE_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0]   st;
      logic         run;
      logic         sd;
      logic [W-1:0] cnt;
      logic [W-1:0] cyc;
   } exp_t;

   exp_t         expq[$];
   logic [W-1:0] retq[$];
   int           checks = 0;
   int           errors = 0;

   // Reference model: mode 0 idle, 1 running, 2 halted; stage 0..4 within an instruction.
   int          m_mode = 0;
   int          m_stage = 0;
   bit          m_hp = 1'b0;
   int unsigned m_cnt = 0;
   int unsigned m_cyc = 0;
   bit          m_sd = 1'b0;

   task automatic model_step(input bit rst, input bit st, input bit sl, input bit hl);
      exp_t e;
      bit   retire;
      retire = 1'b0;
      if (rst) begin
         m_mode = 0; m_stage = 0; m_hp = 1'b0; m_cnt = 0; m_cyc = 0;
      end else begin
         if (m_mode == 1) m_cyc = (m_cyc + 1) & MASK;
         if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_stage = 0; end
         end else if (m_mode == 1 && !sl) begin
            if (m_stage == 1 && hl) m_hp = 1'b1;
            if (m_stage == 4) begin
               retire = 1'b1;
               m_cnt = (m_cnt + 1) & MASK;
               m_mode = m_hp ? 2 : 1;
               m_hp = 1'b0;
               m_stage = 0;
            end else begin
               m_stage = m_stage + 1;
            end
         end
      end
      m_sd = retire;
      e.st  = (m_mode == 0) ? 3'd0 : (m_mode == 2) ? 3'd6 : 3'(m_stage + 1);
      e.run = (m_mode == 1);
      e.sd  = m_sd;
      e.cnt = W'(m_cnt);
      e.cyc = W'(m_cyc);
      expq.push_back(e);
      if (retire) retq.push_back(W'(m_cnt));
   endtask

   task automatic drive(input bit rst, input bit st, input bit sl, input bit hl);
      @(negedge CLK);
      RST = rst; START = st; STALL = sl; HALT = hl;
      model_step(rst, st, sl, hl);
   endtask

   // Monitor: one snapshot per edge, plus the retire count whenever STEP_DONE fires.
   initial begin
      exp_t         e;
      logic [W-1:0] r;
      logic [W-1:0] cyc_act;
      forever begin
         @(posedge CLK);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
`ifdef PROC_CYCLE_CNT_EN
            cyc_act = CYCLE_CNT;
`else
            cyc_act = e.cyc;
`endif
            checks++;
            if (STATE !== e.st || RUNNING !== e.run || STEP_DONE !== e.sd ||
                INSTR_CNT !== e.cnt || cyc_act !== e.cyc) begin
               errors++;
               $display("FAIL snapshot t=%0t got st=%0d run=%0b sd=%0b cnt=%0d cyc=%0d want st=%0d run=%0b sd=%0b cnt=%0d cyc=%0d",
                        $time, STATE, RUNNING, STEP_DONE, INSTR_CNT, cyc_act,
                        e.st, e.run, e.sd, e.cnt, e.cyc);
            end
            if (STEP_DONE === 1'b1) begin
               checks++;
               if (retq.size() == 0) begin
                  errors++;
                  $display("FAIL retire t=%0t got STEP_DONE with cnt=%0d want no retire", $time, INSTR_CNT);
               end else begin
                  r = retq.pop_front();
                  if (INSTR_CNT !== r) begin
                     errors++;
                     $display("FAIL retire_cnt t=%0t got %0d want %0d", $time, INSTR_CNT, r);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  nstall;
      bit  hl;
      // Reset then idle, with stall/halt noise that must be ignored.
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      // Free run: 20 cycles after the START edge.
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b0);
      // Three stall cycles in MEMORY of the first instruction.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      nstall = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_mode == 1 && m_stage == 3 && nstall < 3) begin
            nstall++;
            drive(1'b0, 1'b0, 1'b1, 1'b0);
         end else begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
      // Halt decoded in the 3rd instruction, then START must not leave HALTED.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         hl = (m_mode == 1 && m_stage == 1 && m_cnt == 2);
         drive(1'b0, i > 30, 1'b0, hl);
      end
      // Reset during EXECUTE of the 2nd instruction.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         if (m_mode == 1 && m_cnt == 1 && m_stage == 2) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            break;
         end
         drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      // Wrap: nine instructions on a 3-bit counter.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (46) drive(1'b0, 1'b0, 1'b0, 1'b0);
      // Random traffic.
      repeat (2000)
         drive($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      repeat (3) @(posedge CLK);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending snapshots want 0", expq.size());
      end
      checks++;
      if (retq.size() != 0) begin
         errors++;
         $display("FAIL retire_drain got %0d pending retires want 0", retq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
